hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard.sv | 107 ++++++++++
 tb/tb_hazard_scoreboard.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RV32I decode-to-execute issue slot with a 32-entry RAW/WAW scoreboard and stall watchdog.
// Optional SB_STALL_STATS_EN adds a free-running stall_cycles counter output.
module hazard_scoreboard #(
  parameter int WB_BYPASS     = 1,
  parameter int STALL_TIMEOUT = 64,
  parameter int CNT_W         = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [6:0]  id_opcode,
  input  logic [4:0]  id_rd,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  output logic        id_ready,
  output logic        ex_valid,
  output logic [6:0]  ex_opcode,
  output logic [4:0]  ex_rd,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  input  logic        ex_ready,
  input  logic        flush,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic [31:0] pending,
`ifdef SB_STALL_STATS_EN
  output logic [31:0] stall_cycles,
`endif
  output logic        timeout_err
);
  // Returns {uses_rs1, uses_rs2, writes_rd}.
  function automatic logic [2:0] f_use(input logic [6:0] op);
    logic r, i, s, u;
    r = op == 7'b0110011;
    i = op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111;
    s = op == 7'b0100011 || op == 7'b1100011;
    u = op == 7'b1101111 || op == 7'b0110111 || op == 7'b0010111;
    return {r | i | s, r | s, r | i | u};
  endfunction

  logic [31:0]      r_pending;
  logic             r_ex_valid, r_ex_wr, r_timeout;
  logic [6:0]       r_ex_opcode;
  logic [4:0]       r_ex_rd, r_ex_rs1, r_ex_rs2;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       w_use;
  logic [31:0]      w_eff, w_set, w_clr;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_hazard, w_ready, w_fire, w_kill;

  assign w_use    = f_use(id_opcode);
  assign w_eff    = (WB_BYPASS != 0 && wb_valid) ? r_pending & ~(32'd1 << wb_rd) : r_pending;
  assign w_hazard = id_valid && ((w_use[2] && w_eff[id_rs1]) || (w_use[1] && w_eff[id_rs2]) || (w_use[0] && w_eff[id_rd]));
  assign w_ready  = !w_hazard && !flush && (!r_ex_valid || ex_ready);
  assign w_fire   = id_valid && w_ready;
  // A flushed, unconsumed slot never reaches writeback, so its reservation is dropped.
  assign w_kill   = flush && r_ex_valid && !ex_ready && r_ex_wr;
  assign w_clr    = (wb_valid ? 32'd1 << wb_rd : 32'd0) | (w_kill ? 32'd1 << r_ex_rd : 32'd0);
  assign w_set    = (w_fire && w_use[0]) ? 32'd1 << id_rd : 32'd0;
  assign w_cnt_nxt = (r_cnt == CNT_W'(STALL_TIMEOUT)) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending   <= '0;
      r_ex_valid  <= 1'b0;
      r_ex_wr     <= 1'b0;
      r_ex_opcode <= '0;
      r_ex_rd     <= '0;
      r_ex_rs1    <= '0;
      r_ex_rs2    <= '0;
      r_cnt       <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_pending <= ((r_pending & ~w_clr) | w_set) & ~32'd1;
      if (w_fire) begin
        r_ex_valid  <= 1'b1;
        r_ex_wr     <= w_use[0];
        r_ex_opcode <= id_opcode;
        r_ex_rd     <= id_rd;
        r_ex_rs1    <= id_rs1;
        r_ex_rs2    <= id_rs2;
      end else if (ex_ready || flush) begin
        r_ex_valid <= 1'b0;
      end
      r_cnt <= w_hazard ? w_cnt_nxt : '0;
      if (w_hazard && w_cnt_nxt == CNT_W'(STALL_TIMEOUT)) r_timeout <= 1'b1;
    end
  end

`ifdef SB_STALL_STATS_EN
  logic [31:0] r_stall_cycles;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stall_cycles <= '0;
    else if (id_valid && !w_ready) r_stall_cycles <= r_stall_cycles + 32'd1;
  end
  assign stall_cycles = r_stall_cycles;
`endif

  assign id_ready    = w_ready;
  assign ex_valid    = r_ex_valid;
  assign ex_opcode   = r_ex_opcode;
  assign ex_rd       = r_ex_rd;
  assign ex_rs1      = r_ex_rs1;
  assign ex_rs2      = r_ex_rs2;
  assign pending     = r_pending;
  assign timeout_err = r_timeout;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: table-driven directed check of hazard_scoreboard with STALL_TIMEOUT=4, WB_BYPASS=1.
module tb_hazard_scoreboard;
  localparam logic [6:0] ADD = 7'h33, ADDI = 7'h13, LUI = 7'h37, AUIPC = 7'h17;
  localparam logic [6:0] ST = 7'h23, BR = 7'h63, UNK = 7'h7F;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        id_valid = 0, ex_ready = 0, flush = 0, wb_valid = 0;
  logic [6:0]  id_opcode = '0;
  logic [4:0]  id_rd = '0, id_rs1 = '0, id_rs2 = '0, wb_rd = '0;
  logic        id_ready, ex_valid, timeout_err;
  logic [6:0]  ex_opcode;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic [31:0] pending;
  int checks = 0, errors = 0;
`ifdef SB_STALL_STATS_EN
  logic [31:0] stall_cycles;
  int exp_stalls = 0;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard #(.WB_BYPASS(1), .STALL_TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_ready(id_ready), .ex_valid(ex_valid),
    .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_ready(ex_ready), .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .pending(pending),
`ifdef SB_STALL_STATS_EN
    .stall_cycles(stall_cycles),
`endif
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic v; logic [6:0] op; logic [4:0] rd, rs1, rs2;
    logic er, fl, wv; logic [4:0] wr;
    logic idr, exv; logic [4:0] exrd; logic [31:0] pend; logic to;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                              input logic er, fl, wv, input logic [4:0] wr,
                              input logic idr, exv, input logic [4:0] exrd,
                              input logic [31:0] pend, input logic to);
    vec_t t;
    t.v = v; t.op = op; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
    t.er = er; t.fl = fl; t.wv = wv; t.wr = wr;
    t.idr = idr; t.exv = exv; t.exrd = exrd; t.pend = pend; t.to = to;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  initial begin
    //            v op    rd rs1 rs2 er fl wv wr  idr exv exrd pend       to
    vecs.push_back(mk(1, ADD,   1, 2, 3, 1, 0, 0, 0,  1, 1, 1,  32'h2,   0));
    vecs.push_back(mk(1, ADD,   4, 5, 6, 1, 0, 0, 0,  1, 1, 4,  32'h12,  0));
    vecs.push_back(mk(0, ADD,   0, 0, 0, 1, 0, 1, 1,  1, 0, 4,  32'h10,  0));
    vecs.push_back(mk(0, ADD,   0, 0, 0, 1, 0, 1, 4,  1, 0, 4,  32'h0,   0));
    vecs.push_back(mk(1, ADD,   5, 1, 2, 1, 0, 0, 0,  1, 1, 5,  32'h20,  0));
    vecs.push_back(mk(1, ADD,   8, 5, 0, 1, 0, 0, 0,  0, 0, 5,  32'h20,  0));
    vecs.push_back(mk(1, ADD,   8, 5, 0, 1, 0, 0, 0,  0, 0, 5,  32'h20,  0));
    vecs.push_back(mk(1, ADD,   8, 5, 0, 1, 0, 0, 0,  0, 0, 5,  32'h20,  0));
    vecs.push_back(mk(1, ADD,   8, 5, 0, 1, 0, 1, 5,  1, 1, 8,  32'h100, 0));
    vecs.push_back(mk(0, ADD,   0, 0, 0, 1, 0, 1, 8,  1, 0, 8,  32'h0,   0));
    vecs.push_back(mk(1, ADDI,  7, 1, 0, 1, 0, 0, 0,  1, 1, 7,  32'h80,  0));
    vecs.push_back(mk(1, ADDI,  7, 2, 0, 1, 0, 1, 7,  1, 1, 7,  32'h80,  0));
    vecs.push_back(mk(0, ADD,   0, 0, 0, 1, 0, 1, 7,  1, 0, 7,  32'h0,   0));
    vecs.push_back(mk(1, LUI,   9, 0, 0, 0, 0, 0, 0,  1, 1, 9,  32'h200, 0));
    vecs.push_back(mk(1, ADD,  10, 1, 2, 0, 1, 0, 0,  0, 0, 9,  32'h0,   0));
    vecs.push_back(mk(1, ADD,  10, 1, 2, 0, 0, 0, 0,  1, 1, 10, 32'h400, 0));
    vecs.push_back(mk(0, ADD,   0, 0, 0, 1, 1, 0, 0,  0, 0, 10, 32'h400, 0));
    vecs.push_back(mk(0, ADD,   0, 0, 0, 1, 0, 1, 10, 1, 0, 10, 32'h0,   0));
    vecs.push_back(mk(1, ADDI,  0, 1, 0, 1, 0, 0, 0,  1, 1, 0,  32'h0,   0));
    vecs.push_back(mk(1, UNK,   3, 3, 3, 1, 0, 0, 0,  1, 1, 3,  32'h0,   0));
    vecs.push_back(mk(1, UNK,   3, 3, 3, 1, 0, 0, 0,  1, 1, 3,  32'h0,   0));
    vecs.push_back(mk(1, ST,    0, 4, 5, 1, 0, 0, 0,  1, 1, 0,  32'h0,   0));
    vecs.push_back(mk(1, ADDI,  2, 1, 0, 0, 0, 0, 0,  0, 1, 0,  32'h0,   0));
    vecs.push_back(mk(1, ADDI,  2, 1, 0, 1, 0, 0, 0,  1, 1, 2,  32'h4,   0));
    vecs.push_back(mk(1, BR,    0, 2, 0, 1, 0, 0, 0,  0, 0, 2,  32'h4,   0));
    vecs.push_back(mk(1, BR,    0, 2, 0, 1, 0, 0, 0,  0, 0, 2,  32'h4,   0));
    vecs.push_back(mk(1, BR,    0, 2, 0, 1, 0, 0, 0,  0, 0, 2,  32'h4,   0));
    vecs.push_back(mk(1, BR,    0, 2, 0, 1, 0, 0, 0,  0, 0, 2,  32'h4,   1));
    vecs.push_back(mk(1, BR,    0, 2, 0, 1, 0, 1, 2,  1, 1, 0,  32'h0,   1));
    vecs.push_back(mk(0, ADD,   0, 0, 0, 1, 0, 0, 0,  1, 0, 0,  32'h0,   1));
    vecs.push_back(mk(1, AUIPC, 6, 0, 0, 1, 0, 0, 0,  1, 1, 6,  32'h40,  1));
    vecs.push_back(mk(1, ST,    0, 0, 6, 1, 0, 0, 0,  0, 0, 6,  32'h40,  1));
    vecs.push_back(mk(1, ST,    0, 0, 6, 1, 0, 1, 6,  1, 1, 0,  32'h0,   1));

    repeat (2) @(posedge clk);
    #1;
    chk("rst pending", pending, 0);
    chk("rst ex_valid", ex_valid, 0);
    chk("rst ex_opcode", ex_opcode, 0);
    chk("rst ex_rd", ex_rd, 0);
    chk("rst timeout_err", timeout_err, 0);
    chk("rst id_ready", id_ready, 1);
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      id_valid = vecs[i].v; id_opcode = vecs[i].op; id_rd = vecs[i].rd;
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; ex_ready = vecs[i].er;
      flush = vecs[i].fl; wb_valid = vecs[i].wv; wb_rd = vecs[i].wr;
      #1 chk($sformatf("v%0d id_ready", i), id_ready, vecs[i].idr);
`ifdef SB_STALL_STATS_EN
      if (vecs[i].v && !vecs[i].idr) exp_stalls++;
`endif
      @(posedge clk);
      #1;
      chk($sformatf("v%0d ex_valid", i), ex_valid, vecs[i].exv);
      chk($sformatf("v%0d ex_rd", i), ex_rd, vecs[i].exrd);
      chk($sformatf("v%0d pending", i), pending, vecs[i].pend);
      chk($sformatf("v%0d timeout_err", i), timeout_err, vecs[i].to);
`ifdef SB_STALL_STATS_EN
      chk($sformatf("v%0d stall_cycles", i), stall_cycles, exp_stalls);
`endif
    end

    // Asynchronous reset in the middle of a cycle, then a stale writeback.
    @(negedge clk);
    id_valid = 1; id_opcode = ADD; id_rd = 3; id_rs1 = 1; id_rs2 = 2;
    ex_ready = 1; flush = 0; wb_valid = 0;
    @(posedge clk);
    #1;
    chk("pre-rst pending", pending, 32'h8);
    chk("pre-rst ex_opcode", ex_opcode, ADD);
    chk("pre-rst ex_rs1", ex_rs1, 1);
    chk("pre-rst ex_rs2", ex_rs2, 2);
    #2 rst_n = 1'b0; id_valid = 0;
    #1;
    chk("async rst pending", pending, 0);
    chk("async rst ex_valid", ex_valid, 0);
    chk("async rst ex_rd", ex_rd, 0);
    chk("async rst timeout_err", timeout_err, 0);
`ifdef SB_STALL_STATS_EN
    chk("async rst stall_cycles", stall_cycles, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1; wb_valid = 1; wb_rd = 3;
    @(posedge clk);
    #1 chk("stale wb pending", pending, 0);
    @(negedge clk);
    wb_valid = 0; id_valid = 1; id_opcode = ADD; id_rd = 4; id_rs1 = 3; id_rs2 = 0;
    #1 chk("post-rst id_ready", id_ready, 1);
    @(posedge clk);
    #1;
    chk("post-rst pending", pending, 32'h10);
    chk("post-rst ex_valid", ex_valid, 1);
    @(negedge clk) id_valid = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
